up_axil_bridge: RTL

- AXI4-Lite slave that translates register accesses into the internal up_* request/acknowledge bus consumed by the DAC/ADC cores (up_wreq/up_waddr/up_wdata -> up_wack; up_rreq/up_raddr -> up_rdata/up_rack).
- Initiator end of that bus; sits between the PS/interconnect and a core's processor interface.
- Independent write and read engines, one outstanding transaction each.
- Per-transaction timeout so an unresponsive core cannot hang the AXI bus.

---
 rtl/up_axil_pkg.sv | 7 +
 rtl/up_axil_bridge_if.sv | 34 +++
 rtl/up_axil_xfer.sv | 50 +++++
 rtl/up_axil_bridge.sv | 61 ++++++
 4 files changed

// File: rtl/up_axil_pkg.sv
// up_axil_pkg: shared response codes, timeout read pattern and engine state encoding
package up_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;
  typedef enum logic [2:0] {ST_IDLE, ST_ACCEPT, ST_REQ, ST_WAIT, ST_RESP} xfer_state_t;
endpackage

// File: rtl/up_axil_bridge_if.sv
// up_axil_bridge_if: AXI4-Lite slave channels plus the up_* register bus driven by the bridge
interface up_axil_bridge_if #(parameter int ADDRESS_WIDTH = 16);
  logic s_axi_awvalid, s_axi_awready;
  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr;
  logic [2:0] s_axi_awprot;
  logic s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0] s_axi_wstrb;
  logic s_axi_bvalid, s_axi_bready;
  logic [1:0] s_axi_bresp;
  logic s_axi_arvalid, s_axi_arready;
  logic [ADDRESS_WIDTH-1:0] s_axi_araddr;
  logic [2:0] s_axi_arprot;
  logic s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic up_wreq, up_wack, up_rreq, up_rack;
  logic [ADDRESS_WIDTH-3:0] up_waddr, up_raddr;
  logic [31:0] up_wdata, up_rdata;
  modport slave (
    input s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
          s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
          up_wack, up_rdata, up_rack,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
           s_axi_rvalid, s_axi_rdata, s_axi_rresp, up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );
  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awprot, s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
           s_axi_bready, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
           up_wack, up_rdata, up_rack,
    input s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
          s_axi_rvalid, s_axi_rdata, s_axi_rresp, up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );
endinterface

// File: rtl/up_axil_xfer.sv
// up_axil_xfer: one-outstanding accept/request/wait/response engine with ack timeout
module up_axil_xfer
  import up_axil_pkg::*;
#(parameter int TIMEOUT_CYCLES = 32) (
  input  logic up_clk,
  input  logic up_rstn,
  input  logic i_valid,
  input  logic i_ack,
  input  logic i_resp_ready,
  output logic o_ready,
  output logic o_req,
  output logic o_done,
  output logic o_err,
  output logic o_resp_valid
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  xfer_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic w_wait, w_tmo;
  // the request cycle is the first cycle of the ack window, so a timeout lands TIMEOUT_CYCLES after the request
  assign w_wait = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_tmo = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign o_ready = r_state == ST_ACCEPT;
  assign o_req = r_state == ST_REQ;
  assign o_resp_valid = r_state == ST_RESP;
  always_ff @(posedge up_clk or negedge up_rstn)
    if (!up_rstn) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_wait && !o_done) ? r_cnt + 1'b1 : '0;
    end
  always_comb begin
    w_next = r_state;
    o_done = 1'b0;
    o_err = 1'b0;
    case (r_state)
      ST_IDLE: w_next = i_valid ? ST_ACCEPT : ST_IDLE;
      ST_ACCEPT: w_next = ST_REQ;
      ST_REQ, ST_WAIT: begin
        o_done = i_ack || w_tmo;
        o_err = !i_ack && w_tmo;
        w_next = o_done ? ST_RESP : ST_WAIT;
      end
      ST_RESP: w_next = i_resp_ready ? ST_IDLE : ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/up_axil_bridge.sv
// up_axil_bridge: AXI4-Lite slave to up_* request/ack register bus, independent write and read engines
module up_axil_bridge
  import up_axil_pkg::*;
#(parameter int ADDRESS_WIDTH = 16, parameter int TIMEOUT_CYCLES = 32) (
  input logic up_clk,
  input logic up_rstn,
  up_axil_bridge_if.slave bus
);
  logic w_wr_ready, w_wr_req, w_wr_done, w_wr_err, w_bvalid;
  logic w_rd_ready, w_rd_req, w_rd_done, w_rd_err, w_rvalid;
  logic w_unused;
  logic [ADDRESS_WIDTH-3:0] r_waddr, r_raddr;
  logic [31:0] r_wdata, r_rdata;
  logic [1:0] r_bresp, r_rresp;
  up_axil_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .i_valid(bus.s_axi_awvalid && bus.s_axi_wvalid), .i_ack(bus.up_wack), .i_resp_ready(bus.s_axi_bready),
    .o_ready(w_wr_ready), .o_req(w_wr_req), .o_done(w_wr_done), .o_err(w_wr_err), .o_resp_valid(w_bvalid)
  );
  up_axil_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .i_valid(bus.s_axi_arvalid), .i_ack(bus.up_rack), .i_resp_ready(bus.s_axi_rready),
    .o_ready(w_rd_ready), .o_req(w_rd_req), .o_done(w_rd_done), .o_err(w_rd_err), .o_resp_valid(w_rvalid)
  );
  always_ff @(posedge up_clk or negedge up_rstn)
    if (!up_rstn) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_raddr <= '0;
      r_rdata <= '0;
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
    end else begin
      if (w_wr_ready) begin
        r_waddr <= bus.s_axi_awaddr[ADDRESS_WIDTH-1:2];
        r_wdata <= bus.s_axi_wdata;
      end
      if (w_rd_ready) r_raddr <= bus.s_axi_araddr[ADDRESS_WIDTH-1:2];
      if (w_wr_done) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      if (w_rd_done) begin
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        r_rdata <= w_rd_err ? TIMEOUT_RDATA : bus.up_rdata;
      end
    end
  assign bus.s_axi_awready = w_wr_ready;
  assign bus.s_axi_wready = w_wr_ready;
  assign bus.s_axi_bvalid = w_bvalid;
  assign bus.s_axi_bresp = r_bresp;
  assign bus.s_axi_arready = w_rd_ready;
  assign bus.s_axi_rvalid = w_rvalid;
  assign bus.s_axi_rdata = r_rdata;
  assign bus.s_axi_rresp = r_rresp;
  assign bus.up_wreq = w_wr_req;
  assign bus.up_waddr = r_waddr;
  assign bus.up_wdata = r_wdata;
  assign bus.up_rreq = w_rd_req;
  assign bus.up_raddr = r_raddr;
  // protection, strobes and byte-lane address bits carry no meaning for full-word registers
  assign w_unused = ^{bus.s_axi_awprot, bus.s_axi_arprot, bus.s_axi_wstrb,
                      bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};
endmodule
